// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared branch-prediction types and width defaults
package bp_pkg;

  localparam int PC_W_DEF  = 32;
  localparam int CNT_W_DEF = 32;

  // One in-flight prediction as it travels from fetch toward execute.
  typedef struct packed {
    logic                valid;
    logic [PC_W_DEF-1:0] pc;
    logic                pred_taken;
    logic [PC_W_DEF-1:0] pred_target;
  } pred_t;

endpackage

// File: rtl/pred_stage_reg.sv
// rtl/pred_stage_reg.sv - one pipeline slot of prediction state with stall and flush
module pred_stage_reg
  import bp_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  stall,
  input  logic  flush,
  input  pred_t d,
  output pred_t q
);

  // Flush only kills the slot; the stale payload is harmless once valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (flush) begin
      q.valid <= 1'b0;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - resolves EX-stage branches against carried BTB predictions
module branch_resolve
  import bp_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PC_W-1:0]  PC_IF,
  input  logic             isTakenBr_BTB,
  input  logic [PC_W-1:0]  predictedPC,
  input  logic             stall_ID,
  input  logic             stall_EX,
  input  logic             ex_is_branch,
  input  logic             ex_taken,
  input  logic [PC_W-1:0]  ex_target,
  output logic             mispredict,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             wr_req,
  output logic [PC_W-1:0]  PC_EX,
  output logic [PC_W-1:0]  PC_Branch,
  output logic             isTakenBr_Ex,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pred_t id_d, id_q, ex_d, ex_q;
  logic  resolve, dir_wrong, tgt_wrong;

  always_comb begin
    id_d             = '0;
    id_d.valid       = 1'b1;
    id_d.pc          = PC_IF;
    id_d.pred_taken  = isTakenBr_BTB;
    id_d.pred_target = predictedPC;
  end

  // A held ID stage must not be duplicated into EX, so EX receives a bubble.
  always_comb begin
    ex_d = '0;
    if (!stall_ID) ex_d = id_q;
  end

  pred_stage_reg u_id_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall_ID),
    .flush (mispredict),
    .d     (id_d),
    .q     (id_q)
  );

  pred_stage_reg u_ex_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall_EX),
    .flush (mispredict),
    .d     (ex_d),
    .q     (ex_q)
  );

  assign resolve    = ex_q.valid & ex_is_branch & ~stall_EX;
  assign dir_wrong  = ex_q.pred_taken ^ ex_taken;
  assign tgt_wrong  = ex_q.pred_taken & ex_taken & (ex_q.pred_target != ex_target);
  assign mispredict = resolve & (dir_wrong | tgt_wrong);

  always_comb begin
    redirect_pc = '0;
    if (mispredict) redirect_pc = ex_taken ? ex_target : ex_q.pc + PC_W'(4);
  end

  assign wr_req       = resolve;
  assign PC_EX        = resolve ? ex_q.pc : '0;
  assign PC_Branch    = resolve ? ex_target : '0;
  assign isTakenBr_Ex = resolve & ex_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (resolve && branch_cnt != CNT_MAX) branch_cnt <= branch_cnt + CNT_W'(1);
      if (mispredict && mispredict_cnt != CNT_MAX) mispredict_cnt <= mispredict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - self-checking bench for branch_resolve
module tb_branch_resolve;

  localparam int PC_W  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [PC_W-1:0]  PC_IF = '0;
  logic             isTakenBr_BTB = 1'b0;
  logic [PC_W-1:0]  predictedPC = '0;
  logic             stall_ID = 1'b0;
  logic             stall_EX = 1'b0;
  logic             ex_is_branch = 1'b0;
  logic             ex_taken = 1'b0;
  logic [PC_W-1:0]  ex_target = '0;
  logic             mispredict;
  logic [PC_W-1:0]  redirect_pc;
  logic             wr_req;
  logic [PC_W-1:0]  PC_EX;
  logic [PC_W-1:0]  PC_Branch;
  logic             isTakenBr_Ex;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .PC_IF          (PC_IF),
    .isTakenBr_BTB  (isTakenBr_BTB),
    .predictedPC    (predictedPC),
    .stall_ID       (stall_ID),
    .stall_EX       (stall_EX),
    .ex_is_branch   (ex_is_branch),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .wr_req         (wr_req),
    .PC_EX          (PC_EX),
    .PC_Branch      (PC_Branch),
    .isTakenBr_Ex   (isTakenBr_Ex),
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  // Reference model: what fetch put into each slot, plus plain integer counts.
  bit              m_id_v, m_ex_v, m_id_pt, m_ex_pt;
  logic [PC_W-1:0] m_id_pc, m_id_tgt, m_ex_pc, m_ex_tgt;
  int              m_bc, m_mc;

  function automatic bit e_resolve();
    return m_ex_v && ex_is_branch && !stall_EX;
  endfunction

  function automatic bit e_mispredict();
    if (!e_resolve()) return 1'b0;
    if (m_ex_pt != ex_taken) return 1'b1;
    return ex_taken && (m_ex_tgt != ex_target);
  endfunction

  function automatic logic [PC_W-1:0] e_redirect();
    if (!e_mispredict()) return '0;
    return ex_taken ? ex_target : m_ex_pc + 32'd4;
  endfunction

  task automatic model_reset();
    m_id_v = 0; m_ex_v = 0; m_id_pt = 0; m_ex_pt = 0;
    m_id_pc = '0; m_id_tgt = '0; m_ex_pc = '0; m_ex_tgt = '0;
    m_bc = 0; m_mc = 0;
  endtask

  task automatic model_clock();
    bit res, mp;
    if (!rst_n) begin
      model_reset();
      return;
    end
    res = e_resolve();
    mp  = e_mispredict();
    if (res && m_bc < CMAX) m_bc++;
    if (mp && m_mc < CMAX) m_mc++;
    if (mp) begin
      m_id_v = 0;
      m_ex_v = 0;
      return;
    end
    if (!stall_EX) begin
      if (stall_ID) m_ex_v = 0;
      else begin
        m_ex_v = m_id_v; m_ex_pc = m_id_pc; m_ex_pt = m_id_pt; m_ex_tgt = m_id_tgt;
      end
    end
    if (!stall_ID) begin
      m_id_v = 1; m_id_pc = PC_IF; m_id_pt = isTakenBr_BTB; m_id_tgt = predictedPC;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic drive_if(input logic [PC_W-1:0] pc, input logic pt, input logic [PC_W-1:0] tgt);
    PC_IF = pc; isTakenBr_BTB = pt; predictedPC = tgt;
  endtask

  task automatic drive_ex(input logic br, input logic tk, input logic [PC_W-1:0] tgt);
    ex_is_branch = br; ex_taken = tk; ex_target = tgt;
  endtask

  // Places one predicted branch into EX with a valid non-branch behind it in ID.
  task automatic load_branch(input logic [PC_W-1:0] pc, input logic pt, input logic [PC_W-1:0] tgt);
    stall_ID = 0; stall_EX = 0;
    drive_ex(0, 0, '0);
    drive_if(pc, pt, tgt);
    advance();
    drive_if(pc + 32'd4, 0, '0);
    advance();
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    drive_ex(1, 1, 32'h55);
    drive_if(32'h40, 1, 32'h80);
    @(negedge clk);
    checks++;
    if ({mispredict, wr_req, isTakenBr_Ex} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000", {mispredict, wr_req, isTakenBr_Ex});
    end
    checks++;
    if ({redirect_pc, PC_EX, PC_Branch} !== 96'd0) begin
      errors++; $display("FAIL reset_bus: redirect=%h pc_ex=%h pc_branch=%h expected 0", redirect_pc, PC_EX, PC_Branch);
    end
    checks++;
    if ({branch_cnt, mispredict_cnt} !== 8'd0) begin
      errors++; $display("FAIL reset_cnt: branch=%0d mispredict=%0d expected 0", branch_cnt, mispredict_cnt);
    end
    rst_n = 1;
    #1;
    checks++;
    if ({wr_req, mispredict} !== 2'b00) begin
      errors++; $display("FAIL reset_release_now: wr_req/mispredict=%b expected 00", {wr_req, mispredict});
    end
    advance();
    checks++;
    if ({wr_req, mispredict} !== 2'b00) begin
      errors++; $display("FAIL reset_release_first: wr_req/mispredict=%b expected 00", {wr_req, mispredict});
    end
    drive_ex(0, 0, '0);
    advance();
  endtask

  task automatic test_correct_taken();
    load_branch(32'h100, 1, 32'h200);
    drive_ex(1, 1, 32'h200);
    @(negedge clk);
    checks++;
    if ({mispredict, wr_req, isTakenBr_Ex, PC_EX, PC_Branch, redirect_pc} !== {3'b011, 32'h100, 32'h200, 32'h0}) begin
      errors++;
      $display("FAIL correct_taken: mp=%b wr=%b tk=%b pc_ex=%h pc_br=%h redir=%h expected 0 1 1 100 200 0",
               mispredict, wr_req, isTakenBr_Ex, PC_EX, PC_Branch, redirect_pc);
    end
    advance();
    drive_ex(0, 0, '0);
    checks++;
    if (branch_cnt !== 4'd1 || mispredict_cnt !== 4'd0) begin
      errors++; $display("FAIL correct_taken_cnt: branch=%0d mispredict=%0d expected 1 0", branch_cnt, mispredict_cnt);
    end
    advance();
  endtask

  task automatic test_nt_to_taken();
    load_branch(32'h104, 0, 32'h0);
    drive_ex(1, 1, 32'h180);
    @(negedge clk);
    checks++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h180) begin
      errors++; $display("FAIL nt_to_taken: mp=%b redir=%h expected 1 180", mispredict, redirect_pc);
    end
    advance();
    @(negedge clk);
    checks++;
    if (wr_req !== 1'b0 || mispredict !== 1'b0) begin
      errors++; $display("FAIL flush_ex: wr_req=%b mp=%b expected 0 0", wr_req, mispredict);
    end
    advance();
    @(negedge clk);
    checks++;
    if (wr_req !== 1'b0) begin
      errors++; $display("FAIL flush_id: wr_req=%b expected 0", wr_req);
    end
    checks++;
    if (mispredict_cnt !== CNT_W'(m_mc) || branch_cnt !== CNT_W'(m_bc)) begin
      errors++; $display("FAIL nt_to_taken_cnt: branch=%0d mp=%0d expected %0d %0d", branch_cnt, mispredict_cnt, m_bc, m_mc);
    end
    drive_ex(0, 0, '0);
    advance();
  endtask

  task automatic test_taken_to_nt();
    load_branch(32'h108, 1, 32'h300);
    drive_ex(1, 0, 32'h300);
    @(negedge clk);
    checks++;
    if ({mispredict, wr_req, isTakenBr_Ex, redirect_pc, PC_Branch} !== {3'b110, 32'h10C, 32'h300}) begin
      errors++;
      $display("FAIL taken_to_nt: mp=%b wr=%b tk=%b redir=%h pc_br=%h expected 1 1 0 10c 300",
               mispredict, wr_req, isTakenBr_Ex, redirect_pc, PC_Branch);
    end
    advance();
    drive_ex(0, 0, '0);
    advance();
  endtask

  task automatic test_wrong_target();
    load_branch(32'h200, 1, 32'h300);
    drive_ex(1, 1, 32'h340);
    @(negedge clk);
    checks++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h340 || isTakenBr_Ex !== 1'b1) begin
      errors++; $display("FAIL wrong_target: mp=%b redir=%h tk=%b expected 1 340 1", mispredict, redirect_pc, isTakenBr_Ex);
    end
    advance();
    drive_ex(0, 0, '0);
    checks++;
    if (mispredict_cnt !== CNT_W'(m_mc) || branch_cnt !== CNT_W'(m_bc)) begin
      errors++; $display("FAIL wrong_target_cnt: branch=%0d mp=%0d expected %0d %0d", branch_cnt, mispredict_cnt, m_bc, m_mc);
    end
    advance();
  endtask

  task automatic test_stall_ex();
    int bc_before;
    load_branch(32'h400, 1, 32'h480);
    bc_before = m_bc;
    stall_ID = 1; stall_EX = 1;
    drive_ex(1, 1, 32'h480);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (wr_req !== 1'b0 || branch_cnt !== CNT_W'(bc_before)) begin
        errors++; $display("FAIL stall_ex_hold[%0d]: wr_req=%b branch=%0d expected 0 %0d", i, wr_req, branch_cnt, bc_before);
      end
      advance();
    end
    stall_ID = 0; stall_EX = 0;
    @(negedge clk);
    checks++;
    if (wr_req !== 1'b1 || mispredict !== 1'b0 || PC_EX !== 32'h400) begin
      errors++; $display("FAIL stall_ex_release: wr_req=%b mp=%b pc_ex=%h expected 1 0 400", wr_req, mispredict, PC_EX);
    end
    advance();
    drive_ex(0, 0, '0);
    checks++;
    if (branch_cnt !== CNT_W'(bc_before + 1)) begin
      errors++; $display("FAIL stall_ex_cnt: branch=%0d expected %0d", branch_cnt, bc_before + 1);
    end
    advance();
  endtask

  task automatic test_mid_reset();
    load_branch(32'h500, 1, 32'h600);
    drive_ex(1, 1, 32'h600);
    @(negedge clk);
    checks++;
    if (wr_req !== 1'b1) begin
      errors++; $display("FAIL mid_reset_pre: wr_req=%b expected 1", wr_req);
    end
    #1 rst_n = 0;
    model_reset();
    #1;
    checks++;
    if ({mispredict, wr_req, isTakenBr_Ex, redirect_pc, PC_EX, PC_Branch, branch_cnt, mispredict_cnt} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: wr=%b pc_ex=%h pc_br=%h branch=%0d mp_cnt=%0d expected all 0",
               wr_req, PC_EX, PC_Branch, branch_cnt, mispredict_cnt);
    end
    #1 rst_n = 1;
    #1;
    checks++;
    if (wr_req !== 1'b0) begin
      errors++; $display("FAIL mid_reset_release: wr_req=%b expected 0", wr_req);
    end
    advance();
    @(negedge clk);
    checks++;
    if (wr_req !== 1'b0 || branch_cnt !== 4'd0) begin
      errors++; $display("FAIL mid_reset_first_cycle: wr_req=%b branch=%0d expected 0 0", wr_req, branch_cnt);
    end
    drive_ex(0, 0, '0);
    advance();
  endtask

  task automatic test_back_to_back();
    stall_ID = 0; stall_EX = 0;
    drive_if(32'h800, 0, '0);
    drive_ex(1, 0, 32'h900);
    for (int i = 0; i < 22; i++) begin
      PC_IF = 32'h800 + 32'(i * 4);
      @(negedge clk);
      checks++;
      if (wr_req !== e_resolve() || mispredict !== 1'b0 || branch_cnt !== CNT_W'(m_bc)) begin
        errors++; $display("FAIL back_to_back[%0d]: wr=%b mp=%b branch=%0d expected %b 0 %0d",
                           i, wr_req, mispredict, branch_cnt, e_resolve(), m_bc);
      end
      advance();
    end
    checks++;
    if (branch_cnt !== 4'hF) begin
      errors++; $display("FAIL branch_cnt_saturate: branch=%0d expected 15", branch_cnt);
    end
    drive_ex(0, 0, '0);
  endtask

  task automatic test_random();
    logic            e_res, e_mp;
    logic [PC_W-1:0] e_rd;
    for (int i = 0; i < 400; i++) begin
      stall_ID      = ($urandom_range(0, 3) == 0);
      stall_EX      = ($urandom_range(0, 4) == 0);
      PC_IF         = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFC);
      isTakenBr_BTB = $urandom_range(0, 1);
      predictedPC   = $urandom() & 32'hFFFC;
      ex_is_branch  = ($urandom_range(0, 4) < 3);
      ex_taken      = $urandom_range(0, 1);
      ex_target     = $urandom_range(0, 1) ? m_ex_tgt : ($urandom() & 32'hFFFC);
      if ($urandom_range(0, 2) == 0) ex_taken = m_ex_pt;
      @(negedge clk);
      e_res = e_resolve();
      e_mp  = e_mispredict();
      e_rd  = e_redirect();
      checks++;
      if ({mispredict, wr_req, isTakenBr_Ex, redirect_pc, PC_EX, PC_Branch, branch_cnt, mispredict_cnt} !==
          {e_mp, e_res, e_res & ex_taken, e_rd, e_res ? m_ex_pc : 32'h0, e_res ? ex_target : 32'h0,
           CNT_W'(m_bc), CNT_W'(m_mc)}) begin
        errors++;
        $display("FAIL random[%0d]: mp=%b wr=%b tk=%b redir=%h pc_ex=%h pc_br=%h cnt=%0d/%0d expected %b %b %b %h %h %h %0d/%0d",
                 i, mispredict, wr_req, isTakenBr_Ex, redirect_pc, PC_EX, PC_Branch, branch_cnt, mispredict_cnt,
                 e_mp, e_res, e_res & ex_taken, e_rd, e_res ? m_ex_pc : 32'h0, e_res ? ex_target : 32'h0, m_bc, m_mc);
      end
      advance();
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_correct_taken();
    test_nt_to_taken();
    test_taken_to_nt();
    test_wrong_target();
    test_stall_ex();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
